cactus_generator: RTL and testbench
===================================

// Module: cactus_generator
// PURPOSE
//  Producer of the obstacle geometry consumed by collision_detector: spawns, moves and retires one cactus at a time.
//  Emits cactusX/Y/Height/Width each frame plus a pass pulse for score_counter.
//  Sits between the frame timing logic and collision_detector/renderer.
//  Freezes on game_over so the final collision frame stays on screen.
// PARAMETERS
//  SCREEN_W   320   spawn X; cactus enters at the right edge
//  FLOOR_Y    240   floor line; cactus bottom = FLOOR_Y (y grows downward)
//  MIN_GAP    8     minimum frame_ticks between retire and next spawn
//  LFSR_SEED  8'hA5 nonzero reset seed of the 8-bit LFSR
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-low reset
//  frame_tick     in   1  one-cycle pulse per video frame
//  game_run       in   1  level; high while the game is in play
//  game_over      in   1  level/pulse from game FSM (driven by collision_detect)
//  speed          in   3  pixels moved per frame_tick; 0 treated as 1
//  cactusX        out  9  left edge X of active cactus
//  cactusY        out  9  top edge Y = FLOOR_Y - cactusHeight
//  cactusHeight   out  6  height in pixels
//  cactusWidth    out  6  width in pixels
//  cactus_valid   out  1  high while a cactus is on screen
//  cactus_passed  out  1  one-cycle pulse when a cactus retires off the left edge
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0 at a clk edge): every output 0, FSM=IDLE, LFSR=LFSR_SEED.
//    Reset beats every other input, and mid-operation it takes effect on the next edge.
//  - Whenever cactus_valid==0, cactusX/Y/Height/Width = 0. This all-zero geometry never satisfies collision_detector.
//  - LFSR: 8-bit Fibonacci with taps 8,6,5,4. It steps every clk when reset is deasserted.
//  - FSM states IDLE, GAP, MOVING, FROZEN:
//    IDLE   -> GAP when game_run==1; load gap_cnt = MIN_GAP.
//    GAP    on frame_tick gap_cnt--. When a tick arrives with gap_cnt==1, spawn in the same edge, then -> MOVING.
//           Spawn: type = lfsr[1:0]; height/width taken from the package table; cactusX = SCREEN_W;
//           cactusY = FLOOR_Y - height; cactus_valid = 1; spd_q = max(speed,1).
//    MOVING on frame_tick: if cactusX >= spd_q, then cactusX -= spd_q (1-cycle latency after the tick).
//           Otherwise retire: cactus_passed = 1 for exactly one cycle, outputs zeroed,
//           gap_cnt = MIN_GAP + lfsr[5:2], -> GAP.
//    FROZEN all outputs hold their values; cactus_passed = 0. -> IDLE (outputs zeroed) when game_run==0.
//  - From GAP or MOVING, game_over==1 or game_run==0 takes priority over frame_tick:
//    game_over -> FROZEN (no move that cycle); game_run==0 -> IDLE.
//  - speed is sampled only at spawn; changes mid-flight do not take effect until the next cactus.
//  - Arithmetic: cactusX is 9-bit unsigned and never wraps; the retire test prevents underflow.
//    gap_cnt is 5 bits (max 8+15=23).
//  - game_over while in IDLE is ignored. frame_tick in IDLE/FROZEN is ignored.
// STRUCTURE
//  - dino_pkg: cactus_state_t enum (IDLE, GAP, MOVING, FROZEN); SCREEN_W and FLOOR_Y constants;
//    CACTUS_H[4]={20,30,40,25}; CACTUS_W[4]={10,10,15,20}.
//    The same package is shared with collision_detector and the renderer.
//  - Sub-module lfsr8 (clk, reset, seed -> q[7:0]). The FSM, counters and position registers stay in cactus_generator.
// TESTING
//  1. Hold reset=0 for 3 clk with random inputs -> all outputs 0; after release, LFSR first value follows 8'hA5.
//  2. game_run=1, speed=4: 8 frame_ticks -> after the 8th, cactus_valid=1, cactusX=320,
//     cactusY=240-H[type] with type from the LFSR; next tick -> cactusX=316.
//  3. Moving with cactusX=3, spd_q=4, frame_tick -> cactus_passed high exactly 1 cycle, valid=0,
//     geometry 0, gap_cnt in [8,23].
//  4. game_over and frame_tick asserted in the same cycle at cactusX=200 -> FROZEN, cactusX stays 200
//     over 10 more ticks; then game_run=0 -> IDLE with zeroed outputs.
//  5. speed changed 4->7 mid-flight -> step stays 4 until the next spawn, then becomes 7; speed=0 -> step 1.
//  6. reset pulsed low during MOVING at cactusX=150 -> outputs 0 and IDLE on the next edge.
//     Release with game_run=1 -> next spawn after exactly 8 ticks.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared obstacle definitions for the cactus generator, collision detector and renderer.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        MOVING = 2'd2,
        FROZEN = 2'd3
    } cactus_state_t;

    localparam int SCREEN_W = 320;
    localparam int FLOOR_Y  = 240;

    // Indexed by cactus type: [0]=20x10, [1]=30x10, [2]=40x15, [3]=25x20
    localparam logic [3:0][5:0] CACTUS_H = {6'd25, 6'd40, 6'd30, 6'd20};
    localparam logic [3:0][5:0] CACTUS_W = {6'd20, 6'd15, 6'd10, 6'd10};

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), reloads its seed on reset and steps every clock.
module lfsr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) q <= seed;
        else        q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/cactus_generator.sv
// Spawns, moves and retires a single cactus per frame; freezes on game_over so
// the final collision frame stays on screen.
module cactus_generator #(
    parameter int         SCREEN_W  = dino_pkg::SCREEN_W,
    parameter int         FLOOR_Y   = dino_pkg::FLOOR_Y,
    parameter int         MIN_GAP   = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       game_run,
    input  logic       game_over,
    input  logic [2:0] speed,
    output logic [8:0] cactusX,
    output logic [8:0] cactusY,
    output logic [5:0] cactusHeight,
    output logic [5:0] cactusWidth,
    output logic       cactus_valid,
    output logic       cactus_passed
);
    import dino_pkg::*;

    cactus_state_t state, state_n;
    logic [4:0] gap_cnt, gap_n;
    logic [2:0] spd_q, spd_n;
    logic [8:0] x_n, y_n;
    logic [5:0] h_n, w_n;
    logic       valid_n, passed_n, clr;
    logic [7:0] lfsr_q;
    logic [1:0] lfsr_unused;
    logic [1:0] spawn_type;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    // Only the type and gap-offset fields of the LFSR are consumed.
    assign lfsr_unused = lfsr_q[7:6];
    assign spawn_type  = lfsr_q[1:0];

    always_comb begin
        state_n  = state;
        gap_n    = gap_cnt;
        spd_n    = spd_q;
        x_n      = cactusX;
        y_n      = cactusY;
        h_n      = cactusHeight;
        w_n      = cactusWidth;
        valid_n  = cactus_valid;
        passed_n = 1'b0;
        clr      = 1'b0;
        case (state)
            IDLE: begin
                if (game_run) begin
                    state_n = GAP;
                    gap_n   = 5'(MIN_GAP);
                end
            end
            GAP: begin
                if (game_over)      state_n = FROZEN;
                else if (!game_run) state_n = IDLE;
                else if (frame_tick) begin
                    if (gap_cnt == 5'd1) begin
                        state_n = MOVING;
                        x_n     = 9'(SCREEN_W);
                        h_n     = CACTUS_H[spawn_type];
                        w_n     = CACTUS_W[spawn_type];
                        y_n     = 9'(FLOOR_Y) - {3'b000, CACTUS_H[spawn_type]};
                        valid_n = 1'b1;
                        spd_n   = (speed == 3'd0) ? 3'd1 : speed;
                    end else begin
                        gap_n = gap_cnt - 5'd1;
                    end
                end
            end
            MOVING: begin
                if (game_over) state_n = FROZEN;
                else if (!game_run) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                end else if (frame_tick) begin
                    // Retire instead of stepping past zero, so X never wraps.
                    if (cactusX >= {6'd0, spd_q}) begin
                        x_n = cactusX - {6'd0, spd_q};
                    end else begin
                        state_n  = GAP;
                        passed_n = 1'b1;
                        clr      = 1'b1;
                        gap_n    = 5'(MIN_GAP) + {1'b0, lfsr_q[5:2]};
                    end
                end
            end
            FROZEN: begin
                if (!game_run) begin
                    state_n = IDLE;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                clr     = 1'b1;
            end
        endcase
        if (clr) begin
            x_n     = '0;
            y_n     = '0;
            h_n     = '0;
            w_n     = '0;
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            spd_q         <= '0;
            cactusX       <= '0;
            cactusY       <= '0;
            cactusHeight  <= '0;
            cactusWidth   <= '0;
            cactus_valid  <= 1'b0;
            cactus_passed <= 1'b0;
        end else begin
            state         <= state_n;
            gap_cnt       <= gap_n;
            spd_q         <= spd_n;
            cactusX       <= x_n;
            cactusY       <= y_n;
            cactusHeight  <= h_n;
            cactusWidth   <= w_n;
            cactus_valid  <= valid_n;
            cactus_passed <= passed_n;
        end
    end

endmodule

// File: tb/tb_cactus_generator.sv
// Self-checking bench for cactus_generator: directed vector table, corner sequences
// and a randomized run against a frame-level reference model.
module tb_cactus_generator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       game_run = 1'b0;
    logic       game_over = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [8:0] cactusX, cactusY;
    logic [5:0] cactusHeight, cactusWidth;
    logic       cactus_valid, cactus_passed;

    always #5 clk = ~clk;

    cactus_generator dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .game_run      (game_run),
        .game_over     (game_over),
        .speed         (speed),
        .cactusX       (cactusX),
        .cactusY       (cactusY),
        .cactusHeight  (cactusHeight),
        .cactusWidth   (cactusWidth),
        .cactus_valid  (cactus_valid),
        .cactus_passed (cactus_passed)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: game phase plus the on-screen obstacle as plain integers.
    localparam int PH_IDLE = 0, PH_GAP = 1, PH_MOVE = 2, PH_FROZEN = 3;
    int h_tab[4] = '{20, 30, 40, 25};
    int w_tab[4] = '{10, 10, 15, 20};
    int m_phase, m_gap, m_x, m_y, m_h, m_w, m_valid, m_passed, m_spd, m_lfsr;

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) | fb) & 255;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_obstacle();
        m_x = 0; m_y = 0; m_h = 0; m_w = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        int lf;
        if (reset == 1'b0) begin
            m_phase = PH_IDLE; m_gap = 0; m_spd = 0; m_passed = 0;
            clear_obstacle();
            m_lfsr = 'hA5;
            return;
        end
        lf = m_lfsr;
        m_passed = 0;
        if (m_phase == PH_IDLE) begin
            if (game_run) begin m_phase = PH_GAP; m_gap = 8; end
        end else if (m_phase == PH_FROZEN) begin
            if (!game_run) begin m_phase = PH_IDLE; clear_obstacle(); end
        end else if (game_over) begin
            m_phase = PH_FROZEN;
        end else if (!game_run) begin
            m_phase = PH_IDLE; clear_obstacle();
        end else if (frame_tick && m_phase == PH_GAP) begin
            m_gap--;
            if (m_gap == 0) begin
                m_h = h_tab[lf % 4]; m_w = w_tab[lf % 4];
                m_x = 320; m_y = 240 - m_h; m_valid = 1;
                m_spd = (speed == 0) ? 1 : int'(speed);
                m_phase = PH_MOVE;
            end
        end else if (frame_tick) begin
            if (m_x - m_spd >= 0) m_x = m_x - m_spd;
            else begin
                m_passed = 1; clear_obstacle();
                m_gap = 8 + (lf / 4) % 16;
                m_phase = PH_GAP;
            end
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("model_valid",  cactus_valid,  m_valid);
        check("model_passed", cactus_passed, m_passed);
        check("model_x",      cactusX,       m_x);
        check("model_y",      cactusY,       m_y);
        check("model_h",      cactusHeight,  m_h);
        check("model_w",      cactusWidth,   m_w);
    endtask

    task automatic ticks_until_valid(output int n, input int budget);
        n = 0;
        frame_tick = 1'b1;
        while (cactus_valid !== 1'b1 && n < budget) begin cycle(); n++; end
        frame_tick = 1'b0;
    endtask

    task automatic ticks_until_x(input int target, input int budget);
        int k = 0;
        frame_tick = 1'b1;
        while (int'(cactusX) != target && k < budget) begin cycle(); k++; end
        frame_tick = 1'b0;
        check("reach_x", cactusX, target);
    endtask

    typedef struct {
        logic       rst, gr, go, ft;
        logic [2:0] sp;
        int         exp_valid, exp_x, exp_passed;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int n;
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 0, 0, 0};
        for (int i = 5; i <= 11; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 0, 0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1, 320, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1, 320, 0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1, 316, 0};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1, 312, 0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            reset = tbl[i].rst; game_run = tbl[i].gr; game_over = tbl[i].go;
            frame_tick = tbl[i].ft; speed = tbl[i].sp;
            cycle();
            check("tbl_valid",  cactus_valid,  tbl[i].exp_valid);
            check("tbl_x",      cactusX,       tbl[i].exp_x);
            check("tbl_passed", cactus_passed, tbl[i].exp_passed);
            if (i == 2) check("lfsr_seed",  dut.u_lfsr.q, 'hA5);
            if (i == 3) check("lfsr_first", dut.u_lfsr.q, lfsr_next('hA5));
        end

        // speed 0 behaves as 1; then freeze on game_over+tick at X=200
        game_run = 1'b1; speed = 3'd0; frame_tick = 1'b0; game_over = 1'b0;
        cycle();
        ticks_until_valid(n, 20);
        check("spawn_ticks", n, 8);
        frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
        check("speed0_step", cactusX, 319);
        ticks_until_x(200, 200);
        game_over = 1'b1; frame_tick = 1'b1; cycle();
        check("freeze_x", cactusX, 200);
        game_over = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("frozen_x", cactusX, 200);
        end
        frame_tick = 1'b0; game_run = 1'b0; cycle();
        check("unfreeze_valid", cactus_valid, 0);
        check("unfreeze_x", cactusX, 0);

        // retire off the left edge, then the gap must fall in [8,23]
        game_run = 1'b1; speed = 3'd7; cycle();
        ticks_until_valid(n, 20);
        n = 0;
        frame_tick = 1'b1;
        while (cactus_passed !== 1'b1 && n < 80) begin cycle(); n++; end
        check("retire_pulse", cactus_passed, 1);
        check("retire_valid", cactus_valid, 0);
        check("retire_x", cactusX, 0);
        frame_tick = 1'b0; cycle();
        check("pulse_one_cycle", cactus_passed, 0);
        ticks_until_valid(n, 40);
        check("gap_range", int'(n >= 8 && n <= 23), 1);

        // reset mid-flight at X=150, then a clean 8-tick spawn
        game_run = 1'b0; cycle();
        game_run = 1'b1; speed = 3'd5; cycle();
        ticks_until_valid(n, 20);
        ticks_until_x(150, 60);
        reset = 1'b0; frame_tick = 1'b1; cycle();
        check("rst_valid", cactus_valid, 0);
        check("rst_x", cactusX, 0);
        reset = 1'b1; frame_tick = 1'b0; cycle();
        ticks_until_valid(n, 40);
        check("rst_spawn_ticks", n, 8);

        // randomized play
        for (int i = 0; i < 2500; i++) begin
            reset      = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 99) == 0) game_run = ~game_run;
            game_over  = ($urandom_range(0, 149) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            speed      = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
